// File: rtl/sub_pkg.sv
// Shared definitions for the sequential subtractor: FSM encoding, default slice
// width and a helper to size the slice counter.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_DEF = 4;

    // A single slice still needs a one-bit counter so the vector is never zero-width.
    function automatic int cnt_width(input int nslice);
        if (nslice <= 1) begin
            return 1;
        end else begin
            return $clog2(nslice);
        end
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit slice subtractor: y = a - b - bin, bo = 1 iff a < b + bin.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] y,
    output logic             bo
);

    logic [DIGIT:0] diff_s;

    // One extra bit holds the sign of the difference, which is exactly the borrow out.
    always_comb begin
        diff_s = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    end

    assign y  = diff_s[DIGIT-1:0];
    assign bo = diff_s[DIGIT];

endmodule

// File: rtl/sub_16bit_seq.sv
// Sequential unsigned subtractor: y = a - b - Bin (mod 2^WIDTH), one DIGIT-bit
// slice per clock through a single sub_digit, with valid/ready on both sides.
module sub_16bit_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             Bo
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   y_r;
    logic               borrow_r;
    logic               bo_r;
    logic               out_valid_r;

    logic [DIGIT-1:0]   slice_y_s;
    logic               slice_bo_s;
    logic               accept_s;

    // Operand regs shift right each cycle, so the active slice is always the low DIGIT bits.
    sub_digit #(.DIGIT(DIGIT)) u_slice (
        .a   (a_r[DIGIT-1:0]),
        .b   (b_r[DIGIT-1:0]),
        .bin (borrow_r),
        .y   (slice_y_s),
        .bo  (slice_bo_s)
    );

    assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign Bo        = bo_r;

    // FSM, slice counter, operand shifting and result assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            y_r         <= '0;
            borrow_r    <= 1'b0;
            bo_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            // Covers both a fresh start from IDLE and a back-to-back retire+accept in DONE.
            state_r     <= CALC;
            cnt_r       <= '0;
            a_r         <= a;
            b_r         <= b;
            y_r         <= '0;
            borrow_r    <= Bin;
            bo_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                CALC: begin
                    y_r[int'(cnt_r) * DIGIT +: DIGIT] <= slice_y_s;
                    borrow_r <= slice_bo_s;
                    a_r      <= a_r >> DIGIT;
                    b_r      <= b_r >> DIGIT;
                    cnt_r    <= cnt_r + 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        state_r     <= DONE;
                        bo_r        <= slice_bo_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_16bit_seq.sv
// Self-checking bench for sub_16bit_seq: directed corner cases plus randomized
// traffic with output stalls, checked against a plain arithmetic model.
module tb_sub_16bit_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        Bo;

    int n_vec;
    int n_miss;

    sub_16bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .Bo        (Bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    endfunction

    // Called at a negedge with the block idle: present operands, let one edge accept them.
    task automatic launch(input logic [15:0] la, input logic [15:0] lb, input logic lbin);
        in_valid = 1'b1;
        a        = la;
        b        = lb;
        Bin      = lbin;
        #1;
        check_eq("in_ready_at_launch", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge just after the accepting edge.
    task automatic wait_result(input string tag, input logic [16:0] exp, input bit chk_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
        if (chk_lat) check_eq({tag, "_latency"}, lat, 32'd4);
        check_eq({tag, "_result"}, {15'd0, Bo, y}, {15'd0, exp});
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_retired"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] da, input logic [15:0] db, input logic dbin,
                            input logic [16:0] exp);
        launch(da, db, dbin);
        wait_result(tag, exp, 1'b1);
        retire(tag);
    endtask

    initial begin
        logic [16:0] exp_q[$];
        logic [16:0] got;
        logic [15:0] ra, rb;
        logic        rbin;
        int          sent, recv, cyc;
        bit          pending;

        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'd0;
        b         = 16'd0;
        Bin       = 1'b0;

        #12;
        check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_y_bo", {15'd0, Bo, y}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        directed("t1", 16'h1234, 16'h0034, 1'b0, 17'h0_1200);
        directed("t2", 16'h0000, 16'h0001, 1'b0, 17'h1_FFFF);
        directed("t3a", 16'h8000, 16'h7FFF, 1'b1, 17'h0_0000);
        directed("t3b", 16'h5555, 16'h5555, 1'b1, 17'h1_FFFF);
        directed("zero", 16'h0000, 16'h0000, 1'b0, 17'h0_0000);

        // Backpressure, with a competing producer held off until the consumer is ready.
        launch(16'h00FF, 16'h0001, 1'b0);
        wait_result("bp", 17'h0_00FE, 1'b1);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h1111;
        Bin      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_hold_result", {15'd0, Bo, y}, {15'd0, 17'h0_00FE});
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        a         = 16'h0010;
        b         = 16'h0001;
        Bin       = 1'b0;
        #1;
        check_eq("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("b2b_out_valid_drop", {31'd0, out_valid}, 32'd0);
        wait_result("b2b", 17'h0_000F, 1'b1);
        retire("b2b");

        // Reset two cycles into a calculation.
        launch(16'hFFFF, 16'h0000, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_mid_y_bo", {15'd0, Bo, y}, 32'd0);
        check_eq("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Random traffic with random consumer stalls; results must come back in order.
        sent    = 0;
        recv    = 0;
        cyc     = 0;
        pending = 1'b0;
        ra      = 16'd0;
        rb      = 16'd0;
        rbin    = 1'b0;
        while (recv < 2000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 2000) begin
                ra      = 16'($urandom);
                rb      = 16'($urandom);
                rbin    = 1'($urandom);
                pending = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = pending && ($urandom_range(0, 4) != 0);
            a         = ra;
            b         = rb;
            Bin       = rbin;
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rand_unexpected_result", {15'd0, Bo, y}, 32'hDEAD_BEEF);
                end else begin
                    got = exp_q.pop_front();
                    check_eq("rand_result", {15'd0, Bo, y}, {15'd0, got});
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ra, rb, rbin));
                sent++;
                pending = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("rand_all_received", recv, 32'd2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
